// File: rtl/nec_ir_decoder.sv
// NEC IR frame decoder: synchronises and deglitches the demodulator pin, measures
// mark/space widths in 62.5 us ticks, and decodes frames and repeat codes.
module nec_ir_decoder #(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter bit          RX_ACTIVE_LOW = 1'b1,
  parameter int unsigned GLITCH_CYCLES = 16,
  parameter int unsigned TOL_SHIFT     = 2,
  parameter bit          CHECK_COMMAND = 1'b1,
  parameter int unsigned REPEAT_TICKS  = 1920
) (
  input  logic        clkIN,
  input  logic        resetIN,
  input  logic        rxIN,
  output logic        dataValidOUT,
  output logic        repeatOUT,
  output logic        errorOUT,
  output logic        extendedOUT,
  output logic [15:0] addressOUT,
  output logic [7:0]  commandOUT,
  output logic [31:0] dataOUT
);

  localparam int unsigned TICK_CYCLES = CLK_HZ / 16000;
  localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK, S_RPT_STOP
  } state_t;

  // True when a measured width lies inside nominal +/- max(nominal >> TOL_SHIFT, 1).
  function automatic logic in_win(input logic [7:0] w, input int unsigned nom);
    int unsigned tol;
    int unsigned wv;
    tol = nom >> TOL_SHIFT;
    if (tol == 0) tol = 1;
    wv = {24'd0, w};
    return (wv >= nom - tol) && (wv <= nom + tol);
  endfunction

  logic [1:0]    sync_q;
  logic          filt_q, edge_q, flip;
  logic [GW-1:0] gcnt_q;
  logic [PW-1:0] presc_q;
  logic          tick;
  logic [7:0]    cnt_q;
  state_t        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [31:0]   shift_q, shift_d;
  logic          dv_d, rpt_d, err_d;
  logic          dv_q, rpt_q, err_q;
  logic          win_open_q;
  logic [10:0]   win_cnt_q;
  logic          ext_q;
  logic [15:0]   addr_q;
  logic [7:0]    cmd_q;
  logic [31:0]   data_q;
  logic          rise, fall;

  // Polarity is normalised before the synchroniser so 1 always means mark.
  always_ff @(posedge clkIN or posedge resetIN) begin
    if (resetIN) sync_q <= '0;
    else         sync_q <= {sync_q[0], rxIN ^ RX_ACTIVE_LOW};
  end

  assign flip = (sync_q[1] != filt_q) && (gcnt_q == GW'(GLITCH_CYCLES - 1));

  always_ff @(posedge clkIN or posedge resetIN) begin
    if (resetIN) begin
      filt_q <= 1'b0;
      gcnt_q <= '0;
      edge_q <= 1'b0;
    end else begin
      edge_q <= flip;
      if (flip) filt_q <= ~filt_q;
      if (sync_q[1] == filt_q || flip) gcnt_q <= '0;
      else                             gcnt_q <= gcnt_q + 1'b1;
    end
  end

  assign tick = (presc_q == PW'(TICK_CYCLES - 1));
  assign rise = edge_q & filt_q;
  assign fall = edge_q & ~filt_q;

  always_ff @(posedge clkIN or posedge resetIN) begin
    if (resetIN) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (edge_q)                     cnt_q <= '0;
      else if (tick && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    dv_d    = 1'b0;
    rpt_d   = 1'b0;
    err_d   = 1'b0;
    if (state_q != S_IDLE && !edge_q && cnt_q == 8'hFF) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (rise) state_d = S_LEAD_MARK;
        S_LEAD_MARK: if (fall) begin
          if (in_win(cnt_q, 144)) state_d = S_LEAD_SPACE;
          else begin err_d = 1'b1; state_d = S_IDLE; end
        end
        S_LEAD_SPACE: if (rise) begin
          if (in_win(cnt_q, 72)) begin
            state_d = S_BIT_MARK;
            idx_d   = '0;
          end else if (in_win(cnt_q, 36)) state_d = S_RPT_STOP;
          else begin err_d = 1'b1; state_d = S_IDLE; end
        end
        S_BIT_MARK: if (fall) begin
          if (in_win(cnt_q, 9)) state_d = S_BIT_SPACE;
          else if (in_win(cnt_q, 144)) begin err_d = 1'b1; state_d = S_LEAD_SPACE; end
          else begin err_d = 1'b1; state_d = S_IDLE; end
        end
        S_BIT_SPACE: if (rise) begin
          if (in_win(cnt_q, 9) || in_win(cnt_q, 27)) begin
            shift_d[idx_q] = in_win(cnt_q, 27);
            idx_d          = idx_q + 5'd1;
            state_d        = (idx_q == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
          end else begin err_d = 1'b1; state_d = S_IDLE; end
        end
        S_STOP_MARK: if (fall) begin
          state_d = S_IDLE;
          if (!in_win(cnt_q, 9)) err_d = 1'b1;
          else if (CHECK_COMMAND && shift_q[31:24] != ~shift_q[23:16]) err_d = 1'b1;
          else dv_d = 1'b1;
        end
        S_RPT_STOP: if (fall) begin
          state_d = S_IDLE;
          if (in_win(cnt_q, 9) && win_open_q) rpt_d = 1'b1;
          else                                err_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clkIN or posedge resetIN) begin
    if (resetIN) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      shift_q    <= '0;
      dv_q       <= 1'b0;
      rpt_q      <= 1'b0;
      err_q      <= 1'b0;
      win_open_q <= 1'b0;
      win_cnt_q  <= '0;
      ext_q      <= 1'b0;
      addr_q     <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dv_q    <= dv_d;
      rpt_q   <= rpt_d;
      err_q   <= err_d;
      if (dv_d) begin
        data_q <= shift_q;
        cmd_q  <= shift_q[23:16];
        ext_q  <= (shift_q[15:8] != ~shift_q[7:0]);
        addr_q <= (shift_q[15:8] != ~shift_q[7:0]) ? shift_q[15:0] : {8'h00, shift_q[7:0]};
      end
      if (err_d) win_open_q <= 1'b0;
      else if (dv_d || rpt_d) begin
        win_open_q <= 1'b1;
        win_cnt_q  <= '0;
      end else if (win_open_q && tick) begin
        win_cnt_q <= win_cnt_q + 11'd1;
        if (win_cnt_q == 11'(REPEAT_TICKS - 1)) win_open_q <= 1'b0;
      end
    end
  end

  assign dataValidOUT = dv_q;
  assign repeatOUT    = rpt_q;
  assign errorOUT     = err_q;
  assign extendedOUT  = ext_q;
  assign addressOUT   = addr_q;
  assign commandOUT   = cmd_q;
  assign dataOUT      = data_q;

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Directed bench for nec_ir_decoder: drives NEC waveforms tick by tick and checks
// output pulses (counted on the falling clock edge) and the registered frame fields.
module tb_nec_ir_decoder;
  localparam int CLK_HZ = 64_000;
  localparam int TICK   = CLK_HZ / 16000;

  logic        clkIN = 1'b0;
  logic        resetIN, rxIN;
  logic        dataValidOUT, repeatOUT, errorOUT, extendedOUT;
  logic [15:0] addressOUT;
  logic [7:0]  commandOUT;
  logic [31:0] dataOUT;

  int total = 0, bad = 0;
  int n_dv = 0, n_rpt = 0, n_err = 0, n_multi = 0;
  int d0, r0, e0;

  nec_ir_decoder #(.CLK_HZ(CLK_HZ)) dut (
    .clkIN(clkIN), .resetIN(resetIN), .rxIN(rxIN),
    .dataValidOUT(dataValidOUT), .repeatOUT(repeatOUT), .errorOUT(errorOUT),
    .extendedOUT(extendedOUT), .addressOUT(addressOUT), .commandOUT(commandOUT),
    .dataOUT(dataOUT)
  );

  always #5 clkIN = ~clkIN;

  always @(negedge clkIN) begin
    if (dataValidOUT) n_dv++;
    if (repeatOUT)    n_rpt++;
    if (errorOUT)     n_err++;
    if (int'(dataValidOUT) + int'(repeatOUT) + int'(errorOUT) > 1) n_multi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mark(input int t);
    rxIN = 1'b0;
    repeat (t * TICK) @(negedge clkIN);
  endtask

  task automatic space(input int t);
    rxIN = 1'b1;
    repeat (t * TICK) @(negedge clkIN);
  endtask

  // Space with a 2-cycle false mark in the middle.
  task automatic space_glitch(input int t);
    rxIN = 1'b1;
    repeat (t * TICK / 2) @(negedge clkIN);
    rxIN = 1'b0;
    repeat (2) @(negedge clkIN);
    rxIN = 1'b1;
    repeat (t * TICK - t * TICK / 2 - 2) @(negedge clkIN);
  endtask

  task automatic send_bits(input logic [31:0] d, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      mark(9);
      if (glitch) space_glitch(d[i] ? 27 : 9);
      else        space(d[i] ? 27 : 9);
    end
  endtask

  task automatic send_frame(input logic [31:0] d, input bit glitch);
    mark(144);
    space(72);
    send_bits(d, 32, glitch);
    mark(9);
    space(40);
  endtask

  task automatic send_repeat();
    mark(144);
    space(36);
    mark(9);
    space(40);
  endtask

  task automatic partial(input int n);
    mark(144);
    space(72);
    send_bits(32'h0, n, 1'b0);
  endtask

  task automatic snap();
    d0 = n_dv; r0 = n_rpt; e0 = n_err;
  endtask

  initial begin
    resetIN = 1'b1;
    rxIN    = 1'b1;
    repeat (5) @(negedge clkIN);
    check("rst_valid", {31'd0, dataValidOUT}, 32'd0);
    check("rst_repeat", {31'd0, repeatOUT}, 32'd0);
    check("rst_error", {31'd0, errorOUT}, 32'd0);
    check("rst_ext", {31'd0, extendedOUT}, 32'd0);
    check("rst_addr", {16'd0, addressOUT}, 32'd0);
    check("rst_cmd", {24'd0, commandOUT}, 32'd0);
    check("rst_data", dataOUT, 32'd0);
    resetIN = 1'b0;
    space(20);

    // Repeat code with no preceding frame.
    snap();
    send_repeat();
    check("orphan_rpt_err", n_err, e0 + 1);
    check("orphan_rpt_norpt", n_rpt, r0);

    // Standard address 0x04, command 0x08.
    snap();
    send_frame(32'hF708FB04, 1'b0);
    check("f1_valid", n_dv, d0 + 1);
    check("f1_err", n_err, e0);
    check("f1_data", dataOUT, 32'hF708FB04);
    check("f1_addr", {16'd0, addressOUT}, 32'h0004);
    check("f1_cmd", {24'd0, commandOUT}, 32'h08);
    check("f1_ext", {31'd0, extendedOUT}, 32'd0);

    // Repeat completing 640 ticks (40 ms) after the frame.
    snap();
    space(411);
    send_repeat();
    check("rpt40_pulse", n_rpt, r0 + 1);
    check("rpt40_err", n_err, e0);
    check("rpt40_data", dataOUT, 32'hF708FB04);

    // Repeat completing 3200 ticks (200 ms) after the last repeat.
    snap();
    space(2971);
    send_repeat();
    check("rpt200_err", n_err, e0 + 1);
    check("rpt200_norpt", n_rpt, r0);

    // Command complement fails: 0x55 vs 0xAB.
    snap();
    send_frame(32'hAB55FB04, 1'b0);
    check("chk_err", n_err, e0 + 1);
    check("chk_novalid", n_dv, d0);
    check("chk_data_kept", dataOUT, 32'hF708FB04);
    check("chk_cmd_kept", {24'd0, commandOUT}, 32'h08);

    // Extended address 0x1234, command 0x55.
    snap();
    send_frame(32'hAA551234, 1'b0);
    check("f2_valid", n_dv, d0 + 1);
    check("f2_data", dataOUT, 32'hAA551234);
    check("f2_addr", {16'd0, addressOUT}, 32'h1234);
    check("f2_cmd", {24'd0, commandOUT}, 32'h55);
    check("f2_ext", {31'd0, extendedOUT}, 32'd1);

    // Leader arrives after 10 bits: one error, then the full frame decodes.
    snap();
    partial(10);
    send_frame(32'hF708FB04, 1'b0);
    check("resync_err", n_err, e0 + 1);
    check("resync_valid", n_dv, d0 + 1);
    check("resync_data", dataOUT, 32'hF708FB04);
    check("resync_ext", {31'd0, extendedOUT}, 32'd0);

    // Line stuck in space mid-frame: error only once the count saturates.
    snap();
    partial(5);
    space(200);
    check("stall_no_early_err", n_err, e0);
    space(120);
    check("stall_timeout_err", n_err, e0 + 1);
    check("stall_novalid", n_dv, d0);

    // Reset mid-frame discards the partial frame.
    snap();
    partial(8);
    space(3);
    resetIN = 1'b1;
    repeat (3) @(negedge clkIN);
    resetIN = 1'b0;
    check("midrst_data", dataOUT, 32'd0);
    check("midrst_addr", {16'd0, addressOUT}, 32'd0);
    space(300);
    check("midrst_noerr", n_err, e0);
    check("midrst_novalid", n_dv, d0);
    check("midrst_norpt", n_rpt, r0);

    // Frame with 2-cycle glitches inside every space.
    snap();
    send_frame(32'hAA551234, 1'b1);
    check("glitch_valid", n_dv, d0 + 1);
    check("glitch_err", n_err, e0);
    check("glitch_data", dataOUT, 32'hAA551234);
    check("glitch_addr", {16'd0, addressOUT}, 32'h1234);

    check("pulses_exclusive", n_multi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
